lcd_bl_ctrl: RTL and testbench
==============================

# lcd_bl_ctrl

Parametrised LCD backlight controller for the clk27 domain. It replaces the fixed 3/10/30 s backlight timeout with a CPU-programmable millisecond timeout, PWM brightness and a timed fade-out. An activity toggle from the CPU wakes the backlight, and a force-on input keeps it lit during latency testing. The block drives the LCD_BL pin directly. sys_ctrl/PIO fields feed its inputs.

## Interface
Parameters:
- CLK_HZ, 27000000, clock frequency; ms prescaler terminal count = CLK_HZ/1000-1 (integer division)
- MS_W, 15, width of idle-ms counter and timeout_ms
- PWM_BITS, 8, width of PWM counter, brightness and duty
- FADE_STEP_MS, 2, ms per 1-LSB duty decrement during fade (>=1)

Ports:
- clk27  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  backlight master enable (level)
- force_on  in  1  inhibits timeout/fade, wakes from FADE/DARK
- activity  in  1  toggle input; any change = one activity event
- timeout_ms  in  MS_W  idle timeout in ms; 0 = never time out
- brightness  in  PWM_BITS  target duty
- bl_out  out  1  registered PWM backlight drive
- state  out  2  0 OFF, 1 ON, 2 FADE, 3 DARK (registered)
- ms_tick  out  1  one-cycle pulse on each prescaler wrap

## Operation
- Reset: state=OFF, bl_out=0, ms_tick=0, duty=0, pre_ctr=0, idle_ms=0, fade_ctr=0, pwm_ctr=0, act_prev=0.
- Event: evt = activity ^ act_prev; act_prev <= activity every cycle. A spurious event in the first cycle after reset is allowed; it only clears idle_ms.
- Prescaler: pre_ctr counts 0..CLK_HZ/1000-1 and wraps. ms_tick=1 in the cycle after the wrap. It runs in all states.
- idle_ms: cleared on evt, on force_on, or when leaving OFF. Otherwise it increments on ms_tick and saturates at 2^MS_W-1.
- Priority in every state: enable=0 first, then evt or force_on, then timeout.
- OFF: duty=0, idle_ms=0. When enable=1, go to ON.
- ON: duty<=brightness every cycle. If timeout_ms!=0 and idle_ms>=timeout_ms and no evt/force_on, go to FADE with fade_ctr=0.
- FADE: brightness is ignored. On ms_tick, fade_ctr increments. When fade_ctr reaches FADE_STEP_MS-1, duty decrements by 1 and fade_ctr returns to 0. When duty==0, go to DARK. On evt or force_on, go to ON; duty<=brightness and idle_ms=0 on the same edge.
- DARK: duty=0. On evt or force_on, go to ON.
- enable=0 in any state goes to OFF on the next edge; this overrides evt and force_on.
- timeout_ms is compared continuously. If it is lowered to <=idle_ms while in ON, FADE is entered on the next edge.
- PWM: pwm_ctr is a free-running PWM_BITS counter that wraps. bl_out <= (duty==2^PWM_BITS-1) | (pwm_ctr < duty). duty=0 gives constant 0; full scale gives constant 1.

## Timing
- evt or force_on in cycle n: state/duty updated at edge n+1; bl_out reflects the new duty at edge n+2.
- Timeout: the ms_tick that makes idle_ms reach timeout_ms updates idle_ms at edge t. FADE is entered at t+1.
- Fade length: brightness*FADE_STEP_MS ms (±1 ms phase) from FADE entry to DARK.
- PWM period: 2^PWM_BITS cycles.
- No handshakes. All inputs are static or already synchronous to clk27. The CPU must keep toggle width >=1 cycle.

## Test plan
(Sim params: CLK_HZ=4000, so 4 cycles/ms; MS_W=8; PWM_BITS=4; FADE_STEP_MS=2.)
- Reset with enable=1, brightness=15, timeout_ms=0: state goes OFF→ON; bl_out is constant 1 from cycle 2. It stays ON for 2000 cycles with no fade.
- timeout_ms=5, brightness=8, no activity: FADE is entered 1 cycle after the 5th ms_tick. duty steps 8→0 every 8 cycles. DARK is reached after 64 cycles, then bl_out stays 0.
- Toggle activity in mid-FADE (duty=3): at edge+1, state=ON and duty=8; idle_ms=0. Timeout is retimed from the toggle.
- An evt coincident with the cycle where idle_ms reaches timeout: state stays ON and idle_ms=0.
- force_on held through the timeout: no FADE. force_on asserted in DARK: ON within 1 cycle.
- enable dropped in FADE: OFF on the next edge; bl_out=0 at the edge after. Assert reset_n mid-FADE: all outputs go to 0 asynchronously and state=OFF.

Source files
------------

// File: rtl/lcd_bl_ctrl.sv
// lcd_bl_ctrl
// LCD backlight controller for the clk27 domain.
// - The CPU programs an idle timeout in milliseconds and a PWM brightness.
// - When the timeout expires, the backlight fades out and then goes dark.
// - An activity toggle or force_on brings it back to full brightness.
//
// Ports:
//   clk27       clock
//   reset_n     asynchronous active-low reset
//   enable      backlight master enable (level)
//   force_on    holds the backlight on and wakes it from FADE/DARK
//   activity    toggle input; every change is one activity event
//   timeout_ms  idle timeout in ms, 0 disables the timeout
//   brightness  target PWM duty while ON
//   bl_out      registered PWM drive for the LCD_BL pin
//   state       0 OFF, 1 ON, 2 FADE, 3 DARK
//   ms_tick     one-cycle pulse per millisecond
module lcd_bl_ctrl #(
   parameter int CLK_HZ       = 27000000,
   parameter int MS_W         = 15,
   parameter int PWM_BITS     = 8,
   parameter int FADE_STEP_MS = 2
) (
   input  logic                clk27,
   input  logic                reset_n,
   input  logic                enable,
   input  logic                force_on,
   input  logic                activity,
   input  logic [MS_W-1:0]     timeout_ms,
   input  logic [PWM_BITS-1:0] brightness,
   output logic                bl_out,
   output logic [1:0]          state,
   output logic                ms_tick
);

   localparam int PRE_TC = CLK_HZ / 1000 - 1;
   localparam int PRE_W  = (PRE_TC < 1) ? 1 : $clog2(PRE_TC + 1);
   localparam int FADE_W = (FADE_STEP_MS < 2) ? 1 : $clog2(FADE_STEP_MS);

   localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRE_TC);
   localparam logic [FADE_W-1:0]   FADE_LAST = FADE_W'(FADE_STEP_MS - 1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
   localparam logic [MS_W-1:0]     IDLE_MAX  = '1;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_ON   = 2'd1,
      ST_FADE = 2'd2,
      ST_DARK = 2'd3
   } state_t;

   state_t              cur_state;
   state_t              next_state;
   logic                act_prev;
   logic                evt;
   logic                wake;
   logic                timed_out;
   logic [PRE_W-1:0]    pre_ctr;
   logic [MS_W-1:0]     idle_ms;
   logic [MS_W-1:0]     idle_next;
   logic [FADE_W-1:0]   fade_ctr;
   logic [FADE_W-1:0]   fade_next;
   logic [PWM_BITS-1:0] duty;
   logic [PWM_BITS-1:0] duty_next;
   logic [PWM_BITS-1:0] pwm_ctr;

   // Any edge of the activity toggle is one event; force_on acts the same way.
   // The timeout is compared every cycle, so the CPU can lower it on the fly.
   assign evt       = activity ^ act_prev;
   assign wake      = evt | force_on;
   assign timed_out = (timeout_ms != '0) && (idle_ms >= timeout_ms);
   assign state     = cur_state;

   // State register.
   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
         cur_state <= ST_OFF;
      end else begin
         cur_state <= next_state;
      end
   end

   // Next-state logic.
   // A low enable wins over everything else. After that, a wake event wins over
   // the timeout. Together these fix the priority in every state.
   always_comb begin
      next_state = cur_state;
      if (!enable) begin
         next_state = ST_OFF;
      end else begin
         case (cur_state)
            ST_OFF:  next_state = ST_ON;
            ST_ON:   if (!wake && timed_out) next_state = ST_FADE;
            ST_FADE: begin
               if (wake) begin
                  next_state = ST_ON;
               end else if (duty == '0) begin
                  next_state = ST_DARK;
               end
            end
            ST_DARK: if (wake) next_state = ST_ON;
            default: next_state = ST_OFF;
         endcase
      end
   end

   // Datapath next values, chosen from the state we are moving into.
   // This lets a wake from FADE reload the duty on the same edge.
   // On entry to FADE, duty keeps its last brightness and the fade step
   // counter restarts from zero.
   always_comb begin
      duty_next = duty;
      fade_next = fade_ctr;
      case (next_state)
         ST_ON: begin
            duty_next = brightness;
            fade_next = '0;
         end
         ST_FADE: begin
            if (cur_state != ST_FADE) begin
               fade_next = '0;
            end else if (ms_tick) begin
               if (fade_ctr == FADE_LAST) begin
                  fade_next = '0;
                  if (duty != '0) duty_next = duty - 1'b1;
               end else begin
                  fade_next = fade_ctr + 1'b1;
               end
            end
         end
         default: begin
            duty_next = '0;
            fade_next = '0;
         end
      endcase

      idle_next = idle_ms;
      if (cur_state == ST_OFF || wake) begin
         idle_next = '0;
      end else if (ms_tick && idle_ms != IDLE_MAX) begin
         idle_next = idle_ms + 1'b1;
      end
   end

   // Datapath registers.
   // - The prescaler runs in every state. Its wrap is registered, so ms_tick
   //   lands in the cycle after the wrap.
   // - Full-scale duty forces the output high. Without this, the strict
   //   compare would drop one cycle per PWM period.
   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
         act_prev <= 1'b0;
         pre_ctr  <= '0;
         ms_tick  <= 1'b0;
         idle_ms  <= '0;
         fade_ctr <= '0;
         duty     <= '0;
         pwm_ctr  <= '0;
         bl_out   <= 1'b0;
      end else begin
         act_prev <= activity;
         if (pre_ctr == PRE_LAST) begin
            pre_ctr <= '0;
            ms_tick <= 1'b1;
         end else begin
            pre_ctr <= pre_ctr + 1'b1;
            ms_tick <= 1'b0;
         end
         idle_ms  <= idle_next;
         fade_ctr <= fade_next;
         duty     <= duty_next;
         pwm_ctr  <= pwm_ctr + 1'b1;
         bl_out   <= (duty == DUTY_MAX) || (pwm_ctr < duty);
      end
   end

endmodule

// File: tb/tb_lcd_bl_ctrl.sv
// tb_lcd_bl_ctrl
// Directed bench for lcd_bl_ctrl with 4 clock cycles per ms, 8-bit idle
// counter, 4-bit PWM and 2 ms per fade step. Expected values are queued when
// a step is driven and popped when the DUT output is sampled, #1 after the
// rising edge.
module tb_lcd_bl_ctrl;

   localparam int ST_OFF  = 0;
   localparam int ST_ON   = 1;
   localparam int ST_FADE = 2;
   localparam int ST_DARK = 3;

   logic       clk27;
   logic       reset_n;
   logic       enable;
   logic       force_on;
   logic       activity;
   logic [7:0] timeout_ms;
   logic [3:0] brightness;
   logic       bl_out;
   logic [1:0] state;
   logic       ms_tick;

   typedef struct {
      string       tag;
      logic [31:0] value;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   lcd_bl_ctrl #(
      .CLK_HZ(4000),
      .MS_W(8),
      .PWM_BITS(4),
      .FADE_STEP_MS(2)
   ) dut (
      .clk27(clk27),
      .reset_n(reset_n),
      .enable(enable),
      .force_on(force_on),
      .activity(activity),
      .timeout_ms(timeout_ms),
      .brightness(brightness),
      .bl_out(bl_out),
      .state(state),
      .ms_tick(ms_tick)
   );

   // 10 time-unit clock.
   initial clk27 = 1'b0;
   always #5 clk27 = ~clk27;

   // Hard stop in case the DUT never reaches a waited-for condition.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk27);
      #1;
   endtask

   task automatic applyStimulus(input logic en, input logic fo, input logic toggle,
                                input logic [7:0] tmo, input logic [3:0] bri);
      enable     = en;
      force_on   = fo;
      timeout_ms = tmo;
      brightness = bri;
      if (toggle) activity = ~activity;
   endtask

   task automatic expectValue(input string tag, input logic [31:0] value);
      exp_t e;
      e.tag   = tag;
      e.value = value;
      sb.push_back(e);
   endtask

   task automatic checkOutput(input logic [31:0] observed);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $error("[TB] FAIL scoreboard_empty: observed=%0d expected=none", observed);
      end else begin
         e = sb.pop_front();
         assert (observed === e.value) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", e.tag, observed, e.value);
         end
      end
   endtask

   // Counts bl_out highs over one full PWM period (16 cycles).
   task automatic measureHighs(output int highs);
      highs = 0;
      for (int i = 0; i < 16; i++) begin
         tick(1);
         if (bl_out === 1'b1) highs++;
      end
   endtask

   task automatic waitState(input string tag, input int exp, input int max_cycles);
      int n = 0;
      while (state !== 2'(exp) && n < max_cycles) begin
         tick(1);
         n++;
      end
      expectValue(tag, exp);
      checkOutput(32'(state));
   endtask

   // Aligns to the sample point where ms_tick is high.
   task automatic waitTick(input string tag);
      int n = 0;
      while (ms_tick !== 1'b1 && n < 8) begin
         tick(1);
         n++;
      end
      expectValue(tag, 1);
      checkOutput(32'(ms_tick));
   endtask

   initial begin
      int h;
      int h2;
      int bad;
      int nticks;

      reset_n  = 1'b0;
      activity = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 4'd15);
      tick(2);
      expectValue("reset_state", ST_OFF);  checkOutput(32'(state));
      expectValue("reset_bl", 0);          checkOutput(32'(bl_out));
      expectValue("reset_tick", 0);        checkOutput(32'(ms_tick));

      // Release reset. ON after one edge, full-scale output one edge later.
      reset_n = 1'b1;
      tick(1);
      expectValue("off_to_on", ST_ON);     checkOutput(32'(state));
      expectValue("bl_lag", 0);            checkOutput(32'(bl_out));
      tick(1);
      expectValue("bl_full", 1);           checkOutput(32'(bl_out));

      // timeout_ms = 0: stays ON at constant 1. One ms_tick every 4 cycles.
      bad    = 0;
      nticks = 0;
      for (int i = 0; i < 2000; i++) begin
         tick(1);
         if (state !== 2'(ST_ON) || bl_out !== 1'b1) bad++;
         if (ms_tick === 1'b1) nticks++;
      end
      expectValue("no_timeout_hold", 0);   checkOutput(32'(bad));
      expectValue("ms_tick_count", 500);   checkOutput(32'(nticks));

      // Timeout of 5 ms at brightness 8. The toggle clears the saturated idle
      // count. FADE starts 22 cycles later, and DARK follows 64 cycles after that.
      waitTick("tick_align1");
      applyStimulus(1'b1, 1'b0, 1'b1, 8'd5, 4'd8);
      tick(1);
      measureHighs(h);
      expectValue("on_duty8", 8);          checkOutput(32'(h));
      tick(4);
      expectValue("pre_timeout_on", ST_ON); checkOutput(32'(state));
      tick(1);
      expectValue("fade_entry", ST_FADE);  checkOutput(32'(state));
      tick(63);
      expectValue("fade_last", ST_FADE);   checkOutput(32'(state));
      tick(1);
      expectValue("dark_entry", ST_DARK);  checkOutput(32'(state));
      measureHighs(h);
      measureHighs(h2);
      expectValue("dark_bl_zero", 0);      checkOutput(32'(h + h2));
      expectValue("dark_hold", ST_DARK);   checkOutput(32'(state));

      // Wake from DARK, then toggle mid-fade while duty is 3.
      waitTick("tick_align2");
      applyStimulus(1'b1, 1'b0, 1'b1, 8'd5, 4'd8);
      tick(1);
      expectValue("dark_wake_evt", ST_ON); checkOutput(32'(state));
      tick(21);
      expectValue("fade2_entry", ST_FADE); checkOutput(32'(state));
      tick(42);
      applyStimulus(1'b1, 1'b0, 1'b1, 8'd5, 4'd8);
      tick(1);
      expectValue("fade_wake_evt", ST_ON); checkOutput(32'(state));
      measureHighs(h);
      expectValue("wake_duty8", 8);        checkOutput(32'(h));
      tick(4);
      expectValue("retimed_on", ST_ON);    checkOutput(32'(state));
      tick(1);
      expectValue("retimed_fade", ST_FADE); checkOutput(32'(state));

      // The toggle lands on the ms_tick that would bring idle_ms to the
      // timeout. It must win and restart the count.
      waitTick("tick_align3");
      applyStimulus(1'b1, 1'b0, 1'b1, 8'd5, 4'd8);
      tick(1);
      expectValue("rewake", ST_ON);        checkOutput(32'(state));
      tick(19);
      applyStimulus(1'b1, 1'b0, 1'b1, 8'd5, 4'd8);
      tick(2);
      expectValue("coincident_evt_on", ST_ON);     checkOutput(32'(state));
      tick(19);
      expectValue("coincident_retimed_on", ST_ON); checkOutput(32'(state));
      tick(1);
      expectValue("coincident_retimed_fade", ST_FADE); checkOutput(32'(state));

      // force_on wakes from FADE and blocks the timeout while held.
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd5, 4'd8);
      tick(1);
      expectValue("force_wake_fade", ST_ON); checkOutput(32'(state));
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         tick(1);
         if (state !== 2'(ST_ON)) bad++;
      end
      expectValue("force_hold_on", 0);     checkOutput(32'(bad));
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd5, 4'd8);
      waitState("reach_dark", ST_DARK, 200);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd5, 4'd8);
      tick(1);
      expectValue("force_wake_dark", ST_ON); checkOutput(32'(state));
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd5, 4'd8);

      // Dropping enable in FADE wins over a simultaneous toggle, and force_on
      // does not leave OFF.
      waitState("fade_before_disable", ST_FADE, 100);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'd5, 4'd8);
      tick(1);
      expectValue("disable_off", ST_OFF);  checkOutput(32'(state));
      tick(1);
      expectValue("disable_bl", 0);        checkOutput(32'(bl_out));
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd5, 4'd8);
      measureHighs(h);
      expectValue("off_force_bl", 0);      checkOutput(32'(h));
      expectValue("off_force_state", ST_OFF); checkOutput(32'(state));

      // Asynchronous reset mid-FADE while the PWM output is high.
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd5, 4'd8);
      tick(1);
      expectValue("reenable_on", ST_ON);   checkOutput(32'(state));
      waitState("fade_before_reset", ST_FADE, 100);
      begin
         int n = 0;
         while (bl_out !== 1'b1 && n < 16) begin
            tick(1);
            n++;
         end
      end
      expectValue("bl_high_before_reset", 1); checkOutput(32'(bl_out));
      #2;
      reset_n = 1'b0;
      #1;
      expectValue("async_reset_state", ST_OFF); checkOutput(32'(state));
      expectValue("async_reset_bl", 0);    checkOutput(32'(bl_out));
      expectValue("async_reset_tick", 0);  checkOutput(32'(ms_tick));
      reset_n = 1'b1;
      tick(1);
      expectValue("post_reset_on", ST_ON); checkOutput(32'(state));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
